// File: rtl/loader_pkg.sv
// loader_pkg: shared FSM state types and sizing constants for the RAM serial loader
package loader_pkg;
    localparam int RAM_AW = 4;
    localparam int UART_DATA_BITS = 8;
    typedef enum logic [2:0] {IDLE, LOAD, LAST, CHECK, DONE} state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first receiver with rx synchroniser, start-glitch rejection and stop-bit check
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] data,
    output logic                      byte_valid,
    output logic                      frame_err_pulse
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(UART_DATA_BITS - 1);

    rx_state_t                 state, state_nxt;
    logic                      rx_meta, rx_s, rx_prev;
    logic [CW-1:0]             cnt, cnt_nxt;
    logic [BW-1:0]             bidx, bidx_nxt;
    logic [UART_DATA_BITS-1:0] shreg_nxt;
    logic                      valid_nxt, ferr_nxt;

    // two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {rx_meta, rx_s, rx_prev} <= 3'b111;
        else        {rx_meta, rx_s, rx_prev} <= {rx, rx_meta, rx_s};
    end

    // frame sequencing: half-bit start re-check, then one sample per bit period
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        bidx_nxt  = bidx;
        shreg_nxt = data;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_nxt = '0;
                if (rx_prev && !rx_s) state_nxt = RX_START;
            end
            RX_START: if (cnt == HALF_M1) begin
                cnt_nxt   = '0;
                bidx_nxt  = '0;
                state_nxt = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (cnt == FULL_M1) begin
                cnt_nxt   = '0;
                shreg_nxt = {rx_s, data[UART_DATA_BITS-1:1]};
                bidx_nxt  = bidx + 1'b1;
                if (bidx == LAST_BIT) state_nxt = RX_STOP;
            end
            RX_STOP: if (cnt == FULL_M1) begin
                valid_nxt = rx_s;
                ferr_nxt  = !rx_s;
                state_nxt = RX_IDLE;
            end
            default: state_nxt = RX_IDLE;
        endcase
        if (!enable) begin
            state_nxt = RX_IDLE;
            valid_nxt = 1'b0;
            ferr_nxt  = 1'b0;
        end
    end

    // receiver state, counters, shift register and result pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= RX_IDLE;
            cnt             <= '0;
            bidx            <= '0;
            data            <= '0;
            byte_valid      <= 1'b0;
            frame_err_pulse <= 1'b0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            bidx            <= bidx_nxt;
            data            <= shreg_nxt;
            byte_valid      <= valid_nxt;
            frame_err_pulse <= ferr_nxt;
        end
    end
endmodule

// File: rtl/ram_loader.sv
// ram_loader: UART-fed programmer that fills RAM addresses 0..RAM_DEPTH-1; LOADER_CHECKSUM_EN adds a trailing checksum byte
module ram_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int RAM_DEPTH    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic              rx,
    output logic              prog_mode,
    output logic [RAM_AW-1:0] prog_addr,
    output logic [7:0]        program_data,
    output logic              busy,
    output logic              done,
    output logic              frame_err,
    output logic              checksum_ok
);
    localparam logic [RAM_AW-1:0] LAST_ADDR = RAM_AW'(RAM_DEPTH - 1);

    state_t            state, state_nxt;
    logic              le_q, start, write, bv, ferr_p;
    logic [7:0]        rx_data;
    logic [RAM_AW-1:0] ptr;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (load_en),
        .rx              (rx),
        .data            (rx_data),
        .byte_valid      (bv),
        .frame_err_pulse (ferr_p)
    );

    assign start = load_en && !le_q;
    assign write = (state == LOAD) && bv && load_en;
    assign busy  = state inside {LOAD, LAST, CHECK};

    // next state; dropping load_en anywhere returns to IDLE
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:  state_nxt = start ? LOAD : IDLE;
            LOAD:  state_nxt = (bv && ptr == LAST_ADDR) ? LAST : LOAD;
`ifdef LOADER_CHECKSUM_EN
            LAST:  state_nxt = CHECK;
            CHECK: state_nxt = bv ? DONE : CHECK;
`else
            LAST:  state_nxt = DONE;
`endif
            DONE:  state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        if (!load_en) state_nxt = IDLE;
    end

    // state register and load_en history for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            le_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            le_q  <= load_en;
        end
    end

    // programming port, write pointer and sticky status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog_mode    <= 1'b0;
            prog_addr    <= '0;
            program_data <= '0;
            ptr          <= '0;
            done         <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                ptr       <= '0;
                done      <= 1'b0;
                frame_err <= 1'b0;
            end
            if (write) begin
                prog_addr    <= ptr;
                program_data <= rx_data;
                ptr          <= (ptr + 1'b1) & LAST_ADDR;
            end
            prog_mode <= (write || prog_mode) && (state_nxt == LOAD || state_nxt == LAST);
            if (busy && ferr_p) frame_err <= 1'b1;
            if (state_nxt == DONE && state != DONE) done <= 1'b1;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum;

    // running mod-256 sum of data bytes, compared against the trailing checksum byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum         <= '0;
            checksum_ok <= 1'b0;
        end else if (state == IDLE && start) begin
            sum         <= '0;
            checksum_ok <= 1'b0;
        end else begin
            if (write) sum <= sum + rx_data;
            if (state == CHECK && bv && load_en) checksum_ok <= (rx_data == sum);
        end
    end
`else
    assign checksum_ok = done;
`endif
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: self-checking bench for ram_loader with a RAM model and a byte-order reference model
module tb_ram_loader;
    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_en = 1'b0;
    logic       rx = 1'b1;
    logic       prog_mode;
    logic [3:0] prog_addr;
    logic [7:0] program_data;
    logic       busy, done, frame_err, checksum_ok;

    ram_loader #(.CLKS_PER_BIT(CPB), .RAM_DEPTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_en      (load_en),
        .rx           (rx),
        .prog_mode    (prog_mode),
        .prog_addr    (prog_addr),
        .program_data (program_data),
        .busy         (busy),
        .done         (done),
        .frame_err    (frame_err),
        .checksum_ok  (checksum_ok)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         wr_cnt = 0;
    int         a15_cnt = 0;
    int         bv_cnt = 0;
    int         wbase = 0;
    int         abase = 0;
    logic       pm_prev = 1'b0;
    logic [3:0] pa_prev = '0;
    logic [7:0] pd_prev = '0;
    logic [7:0] mem [16];
    logic [7:0] exp_mem [16];
    logic [7:0] exp_q [$];

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        int         exp_wr;
        logic [3:0] exp_addr;
        bit         exp_ferr;
    } vec_t;
    vec_t tv [17];

    // RAM model and write-event monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (prog_mode) begin
            mem[prog_addr] = program_data;
            if (!pm_prev || prog_addr != pa_prev || program_data != pd_prev) wr_cnt++;
            if (prog_addr == 4'hF) a15_cnt++;
        end
        if (dut.u_rx.byte_valid) bv_cnt++;
        pm_prev = prog_mode;
        pa_prev = prog_addr;
        pd_prev = program_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input bit stop_ok);
        logic [9:0] fr;
        fr = {stop_ok, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic model_byte(input logic [7:0] d);
        exp_mem[exp_q.size() % 16] = d;
        exp_q.push_back(d);
    endtask

    function automatic logic [7:0] model_sum();
        logic [7:0] s = 8'h00;
        foreach (exp_q[i]) s += exp_q[i];
        return s;
    endfunction

    task automatic start_load();
        load_en = 1'b0;
        repeat (2) @(negedge clk);
        load_en = 1'b1;
        repeat (2) @(negedge clk);
        exp_q.delete();
        wbase = wr_cnt;
        abase = a15_cnt;
        chk("start busy", busy, 1);
        chk("start done", done, 0);
        chk("start frame_err", frame_err, 0);
        chk("start prog_mode", prog_mode, 0);
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 16; i++) chk($sformatf("%s mem[%0d]", tag, i), mem[i], exp_mem[i]);
    endtask

    task automatic send_good(input logic [7:0] d);
        send_byte(d, 1'b1);
        model_byte(d);
    endtask

    task automatic end_load(input string tag, input bit bad_ck);
`ifdef LOADER_CHECKSUM_EN
        chk({tag, " check busy"}, busy, 1);
        chk({tag, " check done"}, done, 0);
        chk({tag, " check prog_mode"}, prog_mode, 0);
        send_byte(model_sum() + 8'(bad_ck), 1'b1);
`endif
        chk({tag, " done"}, done, 1);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " prog_mode"}, prog_mode, 0);
        chk({tag, " writes"}, wr_cnt - wbase, 16);
        chk({tag, " addr15 cycles"}, a15_cnt - abase, 1);
        chk({tag, " checksum_ok"}, checksum_ok, {31'b0, !bad_ck});
        check_mem(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bv0;
        for (int k = 0; k < 17; k++) begin
            tv[k].data     = 8'h30 + 8'(k < 4 ? k : k - 1);
            tv[k].stop_ok  = (k != 3);
            tv[k].exp_wr   = k < 3 ? k + 1 : k;
            tv[k].exp_addr = 4'(k < 3 ? k : k - 1);
            tv[k].exp_ferr = (k >= 3);
        end

        repeat (3) @(negedge clk);
        chk("reset prog_mode", prog_mode, 0);
        chk("reset prog_addr", prog_addr, 0);
        chk("reset program_data", program_data, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset frame_err", frame_err, 0);
        chk("reset checksum_ok", checksum_ok, 0);
        rst_n = 1'b1;
        @(negedge clk);

        start_load();
        bv0 = bv_cnt;
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        chk("glitch byte_valid", bv_cnt - bv0, 0);
        chk("glitch writes", wr_cnt - wbase, 0);
        chk("glitch prog_mode", prog_mode, 0);
        chk("glitch busy", busy, 1);

        for (int k = 0; k < 17; k++) begin
            send_byte(tv[k].data, tv[k].stop_ok);
            if (tv[k].stop_ok) model_byte(tv[k].data);
            chk($sformatf("tv%0d writes", k), wr_cnt - wbase, tv[k].exp_wr);
            chk($sformatf("tv%0d addr", k), prog_addr, tv[k].exp_addr);
            chk($sformatf("tv%0d data", k), program_data, 8'h30 + 8'(tv[k].exp_addr));
            chk($sformatf("tv%0d frame_err", k), frame_err, tv[k].exp_ferr);
        end
        end_load("table", 1'b0);
        chk("table frame_err sticky", frame_err, 1);

        load_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle done holds", done, 1);
        chk("idle busy", busy, 0);

        start_load();
        for (int i = 0; i < 5; i++) send_good(8'($urandom_range(0, 255)));
        chk("abort pre writes", wr_cnt - wbase, 5);
        chk("abort pre addr", prog_addr, 4);
        load_en = 1'b0;
        @(posedge clk);
        #1;
        chk("abort prog_mode", prog_mode, 0);
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        @(negedge clk);
        check_mem("abort");

        for (int r = 0; r < 2; r++) begin
            start_load();
            for (int i = 0; i < 16; i++) send_good(8'($urandom_range(0, 255)));
            end_load($sformatf("rand%0d", r), 1'b0);
        end

`ifdef LOADER_CHECKSUM_EN
        start_load();
        for (int i = 0; i < 16; i++) send_good(8'h01);
        end_load("cksum good", 1'b0);
        start_load();
        for (int i = 0; i < 16; i++) send_good(8'h01);
        end_load("cksum bad", 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
